// File: rtl/spi_flash_tf_ctrl_if.sv
// Host-side register and buffer bus of the SPI flash/TF controller.
// The master modport is the host; the slave modport is the controller.
interface spi_flash_tf_ctrl_if;
    logic [9:0]  BufAddr;
    logic [7:0]  WriteData;
    logic        WriteTXBuffer;
    logic        WriteSPICntLo;
    logic        WriteSPICntHi;
    logic        WriteSPICnt2;
    logic [15:0] RXBufData;
    logic [15:0] SPICnt;
    logic [7:0]  SPICnt2;

    modport master (
        output BufAddr, WriteData, WriteTXBuffer, WriteSPICntLo, WriteSPICntHi, WriteSPICnt2,
        input  RXBufData, SPICnt, SPICnt2
    );

    modport slave (
        input  BufAddr, WriteData, WriteTXBuffer, WriteSPICntLo, WriteSPICntHi, WriteSPICnt2,
        output RXBufData, SPICnt, SPICnt2
    );
endinterface

// File: rtl/spi_flash_tf_ctrl.sv
// Single-clock SPI master with two ping-pong 512-byte TX/RX banks, serving either
// the flash or the TF card; the slow SCK is derived from a phase counter enable.
module spi_flash_tf_ctrl #(
    parameter int SLOW_DIV = 64
) (
    input  logic               Clk,
    input  logic               nReset,
    spi_flash_tf_ctrl_if.slave host,
    input  logic               TFPow,
    output logic               FlashDo,
    output logic               FlashClk,
    output logic               nFlashSel,
    input  logic               FlashDi,
    output logic               TFDo,
    output logic               TFClk,
    output logic               nTFSel,
    input  logic               TFDi
);
    localparam int DIV_W = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [7:0] tx_mem [0:1023];
    logic [7:0] rx_mem [0:1023];

    logic [0:0]       state_q, state_d;
    logic             bank_q, bank_d;
    logic [1:0]       mode_q, mode_d;
    logic [8:0]       len_q, len_d;
    logic [2:0]       cnt2_q, cnt2_d;
    logic             sck_q, sck_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             slow_q, slow_d;
    logic [2:0]       bit_q, bit_d;
    logic [8:0]       idx_q, idx_d;
    logic [7:0]       txsh_q, txsh_d;
    logic [7:0]       rxsh_q, rxsh_d;
    logic             wait_q, wait_d;
    logic             abort_q, abort_d;

    logic       busy, phase_end, flash_on, tf_on, di, keep;
    logic       rx_we;
    logic [9:0] rx_waddr;
    logic       unused_bufaddr9;

    assign unused_bufaddr9 = host.BufAddr[9];
    assign busy      = (state_q == ST_BUSY);
    assign phase_end = (div_q == (slow_q ? DIV_W'(SLOW_DIV - 1) : '0));

    assign flash_on  = (cnt2_q[2:1] == 2'd2);
    assign tf_on     = (cnt2_q[2:1] == 2'd1);
    assign nFlashSel = ~flash_on;
    assign FlashClk  = flash_on & sck_q;
    assign FlashDo   = flash_on ? txsh_q[7] : 1'b1;
    assign nTFSel    = ~(tf_on & TFPow);
    assign TFClk     = tf_on & TFPow & sck_q;
    assign TFDo      = TFPow & (tf_on ? txsh_q[7] : 1'b1);
    assign di        = flash_on ? FlashDi : (tf_on ? TFDi : 1'b1);

    assign host.SPICnt  = {busy, bank_q, mode_q, 3'b000, len_q};
    assign host.SPICnt2 = {5'b00000, cnt2_q};

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        mode_d   = mode_q;
        len_d    = len_q;
        cnt2_d   = cnt2_q;
        sck_d    = sck_q;
        div_d    = div_q;
        slow_d   = slow_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        txsh_d   = txsh_q;
        rxsh_d   = rxsh_q;
        wait_d   = wait_q;
        abort_d  = abort_q;
        keep     = 1'b0;
        rx_we    = 1'b0;
        rx_waddr = {~bank_q, idx_q};
        if (!busy) begin
            if (host.WriteSPICntLo) len_d[7:0] = host.WriteData;
            if (host.WriteSPICnt2)  cnt2_d = host.WriteData[2:0];
            if (host.WriteSPICntHi) begin
                bank_d   = host.WriteData[6];
                mode_d   = host.WriteData[5:4];
                len_d[8] = host.WriteData[0];
                if (host.WriteData[7]) begin
                    state_d = ST_BUSY;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    slow_d  = cnt2_q[0];
                    bit_d   = 3'd0;
                    idx_d   = 9'd0;
                    wait_d  = (host.WriteData[5:4] == 2'd3);
                    abort_d = 1'b0;
                    // Modes 1 and 2 transmit buffer data, modes 0 and 3 transmit FF.
                    txsh_d  = (host.WriteData[5] ^ host.WriteData[4]) ?
                              tx_mem[{~host.WriteData[6], 9'd0}] : 8'hFF;
                end
            end
        end else begin
            if (host.WriteSPICntHi && !host.WriteData[7]) abort_d = 1'b1;
            if (!phase_end) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d  = 1'b1;
                    rxsh_d = {rxsh_q[6:0], di};
                end else begin
                    sck_d  = 1'b0;
                    slow_d = cnt2_q[0];
                    if (bit_q != 3'd7) begin
                        bit_d  = bit_q + 3'd1;
                        txsh_d = {txsh_q[6:0], 1'b1};
                    end else begin
                        bit_d = 3'd0;
                        // A byte counts toward the length unless aborted or still in the FF preamble.
                        keep  = !abort_q && !(wait_q && rxsh_q == 8'hFF);
                        rx_we = keep && (mode_q != 2'd1);
                        if (keep) wait_d = 1'b0;
                        if (abort_q || (keep && idx_q == len_q)) begin
                            state_d = ST_IDLE;
                            txsh_d  = 8'hFF;
                        end else begin
                            if (keep) idx_d = idx_q + 9'd1;
                            txsh_d = (mode_q[1] ^ mode_q[0]) ? tx_mem[{~bank_q, idx_d}] : 8'hFF;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            bank_q  <= 1'b0;
            mode_q  <= 2'd0;
            len_q   <= 9'd0;
            cnt2_q  <= 3'd0;
            sck_q   <= 1'b0;
            div_q   <= '0;
            slow_q  <= 1'b0;
            bit_q   <= 3'd0;
            idx_q   <= 9'd0;
            txsh_q  <= 8'hFF;
            wait_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt2_q  <= cnt2_d;
            sck_q   <= sck_d;
            div_q   <= div_d;
            slow_q  <= slow_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            txsh_q  <= txsh_d;
            wait_q  <= wait_d;
            abort_q <= abort_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (host.WriteTXBuffer) tx_mem[{bank_q, host.BufAddr[8:0]}] <= host.WriteData;
        if (rx_we) rx_mem[rx_waddr] <= rxsh_q;
        rxsh_q <= rxsh_d;
        host.RXBufData <= {rx_mem[{bank_q, host.BufAddr[8:1], 1'b1}],
                           rx_mem[{bank_q, host.BufAddr[8:1], 1'b0}]};
    end
endmodule

// File: tb/tb_spi_flash_tf_ctrl.sv
// Directed bench for spi_flash_tf_ctrl: an SPI-slave model plus scoreboards of
// expected MOSI bytes and expected host-visible RX words.
module tb_spi_flash_tf_ctrl;
    logic Clk = 1'b0;
    logic nReset = 1'b0;
    logic TFPow = 1'b0;
    logic FlashDo, FlashClk, nFlashSel, TFDo, TFClk, nTFSel;
    logic di;

    spi_flash_tf_ctrl_if bus();

    spi_flash_tf_ctrl #(.SLOW_DIV(64)) dut (
        .Clk(Clk), .nReset(nReset), .host(bus), .TFPow(TFPow),
        .FlashDo(FlashDo), .FlashClk(FlashClk), .nFlashSel(nFlashSel), .FlashDi(di),
        .TFDo(TFDo), .TFClk(TFClk), .nTFSel(nTFSel), .TFDi(di)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] word;
    } rx_exp_t;

    logic [7:0] miso_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_tx_q[$];
    rx_exp_t    exp_rx_q[$];

    // SPI mode-0 slave: shifts on the falling SCK edge, samples MOSI on the rising edge.
    logic [7:0] cur = 8'hFF;
    logic [7:0] shin = 8'h00;
    int         bitn = 0;
    bit         have = 1'b0;
    logic       sck_prev = 1'b0;
    int         flash_edges = 0;
    wire        dsck  = FlashClk | TFClk;
    wire        dmosi = nFlashSel ? TFDo : FlashDo;

    assign di = (have && bitn < 8) ? cur[7 - bitn] : 1'b1;

    always @(negedge Clk) begin
        if (!have && miso_q.size() > 0) begin
            cur  = miso_q.pop_front();
            have = 1'b1;
        end
        if (dsck && !sck_prev) begin
            shin = {shin[6:0], dmosi};
            bitn++;
        end else if (!dsck && sck_prev && bitn == 8) begin
            got_q.push_back(shin);
            bitn = 0;
            have = 1'b0;
            if (miso_q.size() > 0) begin
                cur  = miso_q.pop_front();
                have = 1'b1;
            end
        end
        sck_prev = dsck;
    end

    always @(posedge FlashClk) flash_edges++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wr_tx(input logic [9:0] a, input logic [7:0] d);
        bus.BufAddr = a; bus.WriteData = d; bus.WriteTXBuffer = 1'b1;
        tick();
        bus.WriteTXBuffer = 1'b0;
    endtask

    task automatic wr_lo(input logic [7:0] d);
        bus.WriteData = d; bus.WriteSPICntLo = 1'b1;
        tick();
        bus.WriteSPICntLo = 1'b0;
    endtask

    task automatic wr_hi(input logic [7:0] d);
        bus.WriteData = d; bus.WriteSPICntHi = 1'b1;
        tick();
        bus.WriteSPICntHi = 1'b0;
    endtask

    task automatic wr_cnt2(input logic [7:0] d);
        bus.WriteData = d; bus.WriteSPICnt2 = 1'b1;
        tick();
        bus.WriteSPICnt2 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.SPICnt[15] && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(bus.SPICnt[15]), 32'd0);
        tick(2);
    endtask

    task automatic drain_tx(input string tag);
        chk({tag, "_nbytes"}, got_q.size(), exp_tx_q.size());
        while (got_q.size() > 0 && exp_tx_q.size() > 0)
            chk({tag, "_mosi"}, 32'(got_q.pop_front()), 32'(exp_tx_q.pop_front()));
        got_q.delete();
        exp_tx_q.delete();
    endtask

    task automatic drain_rx(input string tag);
        rx_exp_t     e;
        logic [15:0] w;
        while (exp_rx_q.size() > 0) begin
            e = exp_rx_q.pop_front();
            bus.BufAddr = e.addr;
            tick();
            w = bus.RXBufData;
            chk($sformatf("%s_rx%0d", tag, e.addr), 32'(w), 32'(e.word));
        end
    endtask

    task automatic push_rx(input logic [9:0] a, input logic [15:0] w);
        rx_exp_t e;
        e.addr = a;
        e.word = w;
        exp_rx_q.push_back(e);
    endtask

    initial begin
        int          fe;
        logic [7:0]  pat [4];

        bus.BufAddr = '0; bus.WriteData = '0; bus.WriteTXBuffer = 1'b0;
        bus.WriteSPICntLo = 1'b0; bus.WriteSPICntHi = 1'b0; bus.WriteSPICnt2 = 1'b0;

        tick(3);
        chk("rst_spicnt",  32'(bus.SPICnt), 32'h0);
        chk("rst_spicnt2", 32'(bus.SPICnt2), 32'h0);
        chk("rst_nflash",  32'(nFlashSel), 32'd1);
        chk("rst_ntf",     32'(nTFSel), 32'd1);
        chk("rst_fclk",    32'(FlashClk), 32'd0);
        chk("rst_fdo",     32'(FlashDo), 32'd1);
        nReset = 1'b1;
        tick(2);

        // Prefill bank-0 RX bytes 0..7 with 00 using a fast read.
        wr_cnt2(8'h04);
        wr_lo(8'h07);
        for (int i = 0; i < 8; i++) begin
            miso_q.push_back(8'h00);
            exp_tx_q.push_back(8'hFF);
        end
        wr_hi(8'hC0);
        chk("pre_start", 32'(bus.SPICnt), 32'hC007);
        wait_idle("pre", 400);
        chk("pre_keep", 32'(bus.SPICnt), 32'h4007);
        drain_tx("pre");
        wr_hi(8'h00);

        // Slow exchange on the flash.
        wr_cnt2(8'h00);
        chk("x_nflash_before", 32'(nFlashSel), 32'd1);
        pat = '{8'hAB, 8'hCD, 8'hEF, 8'h12};
        for (int i = 0; i < 4; i++) begin
            wr_tx(10'(i), pat[i]);
            exp_tx_q.push_back(pat[i]);
        end
        wr_lo(8'h03);
        wr_cnt2(8'h05);
        chk("x_nflash_sel", 32'(nFlashSel), 32'd0);
        miso_q.push_back(8'hFF); miso_q.push_back(8'h3E);
        miso_q.push_back(8'hCA); miso_q.push_back(8'h04);
        wr_hi(8'hE0);
        tick(200);
        chk("x_slow_busy", 32'(bus.SPICnt[15]), 32'd1);
        wait_idle("x", 6000);
        drain_tx("x");
        wr_hi(8'h00);
        wr_cnt2(8'h00);
        chk("x_nflash_after", 32'(nFlashSel), 32'd1);
        push_rx(10'd0, 16'h3EFF);
        push_rx(10'd2, 16'h04CA);
        push_rx(10'd4, 16'h0000);
        drain_rx("x");

        // Fast wait-and-read.
        wr_cnt2(8'h04);
        wr_lo(8'h04);
        pat = '{8'hFF, 8'hFF, 8'hFF, 8'h53};
        for (int i = 0; i < 4; i++) miso_q.push_back(pat[i]);
        pat = '{8'h85, 8'hF0, 8'hFF, 8'h21};
        for (int i = 0; i < 4; i++) miso_q.push_back(pat[i]);
        for (int i = 0; i < 8; i++) exp_tx_q.push_back(8'hFF);
        wr_hi(8'hF0);
        wait_idle("w", 400);
        drain_tx("w");
        wr_hi(8'h00);
        push_rx(10'd0, 16'h8553);
        push_rx(10'd2, 16'hFFF0);
        push_rx(10'd4, 16'h0021);
        drain_rx("w");

        // Abort of an endless FF preamble.
        wr_lo(8'h00);
        wr_hi(8'hF0);
        tick(20);
        chk("ab_busy", 32'(bus.SPICnt[15]), 32'd1);
        wr_hi(8'h00);
        wait_idle("ab", 20);
        chk("ab_cnt", 32'(bus.SPICnt), 32'h7000);
        got_q.delete();
        wr_hi(8'h00);
        push_rx(10'd0, 16'h8553);
        push_rx(10'd2, 16'hFFF0);
        drain_rx("ab");

        // Single-byte slow wait-and-read.
        wr_cnt2(8'h05);
        wr_lo(8'h00);
        for (int i = 0; i < 6; i++) miso_q.push_back(8'hFF);
        miso_q.push_back(8'hE3);
        for (int i = 0; i < 7; i++) exp_tx_q.push_back(8'hFF);
        wr_hi(8'hF0);
        wait_idle("s1", 8000);
        drain_tx("s1");
        wr_hi(8'h00);
        push_rx(10'd0, 16'h85E3);
        drain_rx("s1");

        // Write mode on the TF card, engine using bank 1.
        wr_cnt2(8'h02);
        TFPow = 1'b1;
        tick();
        chk("tf_ntf_sel", 32'(nTFSel), 32'd0);
        chk("tf_nflash",  32'(nFlashSel), 32'd1);
        wr_hi(8'h40);
        pat = '{8'h5A, 8'hC3, 8'h0F, 8'h96};
        for (int i = 0; i < 4; i++) begin
            wr_tx(10'(i), pat[i]);
            exp_tx_q.push_back(pat[i]);
            miso_q.push_back(8'h77);
        end
        wr_lo(8'h03);
        fe = flash_edges;
        wr_hi(8'h90);
        wait_idle("tf", 200);
        drain_tx("tf");
        chk("tf_flash_quiet", 32'(flash_edges), 32'(fe));
        chk("tf_nflash_hold", 32'(nFlashSel), 32'd1);
        push_rx(10'd0, 16'h85E3);
        drain_rx("tf");
        TFPow = 1'b0;
        tick();
        chk("tfoff_ntf", 32'(nTFSel), 32'd1);
        chk("tfoff_clk", 32'(TFClk), 32'd0);
        chk("tfoff_do",  32'(TFDo), 32'd0);

        // Asynchronous reset in the middle of a byte.
        TFPow = 1'b1;
        wr_cnt2(8'h04);
        wr_lo(8'h03);
        wr_hi(8'hC0);
        tick(5);
        chk("mid_busy", 32'(bus.SPICnt[15]), 32'd1);
        nReset = 1'b0;
        #1;
        chk("arst_busy",   32'(bus.SPICnt[15]), 32'd0);
        chk("arst_nflash", 32'(nFlashSel), 32'd1);
        chk("arst_ntf",    32'(nTFSel), 32'd1);
        chk("arst_fclk",   32'(FlashClk), 32'd0);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
